// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: PC, imem handshake, IF/ID register
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic        imem_rd_en,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic [15:0] pc_cur,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc,
  output logic        ifid_valid,
  output logic        halted
);

  typedef enum logic [1:0] {S_FETCH, S_DROP, S_HALTED} state_t;

  state_t      state, state_nx;
  logic [15:0] pc, pc_nx;
  logic [15:0] drop_addr, drop_addr_nx;
  logic [15:0] ifid_instr_nx, ifid_pc_nx;
  logic        ifid_valid_nx, halted_nx;
  logic [15:0] redirect_target;

  assign redirect_target = redirect_pc & 16'hFFFE;
  assign pc_cur          = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      drop_addr  <= 16'h0000;
      ifid_instr <= 16'h0000;
      ifid_pc    <= 16'h0000;
      ifid_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      drop_addr  <= drop_addr_nx;
      ifid_instr <= ifid_instr_nx;
      ifid_pc    <= ifid_pc_nx;
      ifid_valid <= ifid_valid_nx;
      halted     <= halted_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    drop_addr_nx  = drop_addr;
    ifid_instr_nx = ifid_instr;
    ifid_pc_nx    = ifid_pc;
    ifid_valid_nx = ifid_valid;
    halted_nx     = halted;
    imem_rd_en    = 1'b0;
    imem_addr     = pc;

    case (state)
      S_FETCH: begin
        imem_rd_en = rst_n;
        if (redirect_en) begin
          pc_nx         = redirect_target;
          ifid_valid_nx = 1'b0;
          // An outstanding read must still be retired before the new address goes out.
          if (!imem_valid) begin
            drop_addr_nx = pc;
            state_nx     = S_DROP;
          end
        end else if (stall) begin
          ifid_valid_nx = ifid_valid;
        end else if (imem_valid) begin
          ifid_instr_nx = imem_data;
          ifid_pc_nx    = pc;
          ifid_valid_nx = 1'b1;
          pc_nx         = pc + 16'd2;
          if (imem_data[15:12] == HALT_OPCODE) begin
            halted_nx = 1'b1;
            state_nx  = S_HALTED;
          end
        end else begin
          ifid_valid_nx = 1'b0;
        end
      end
      S_DROP: begin
        imem_rd_en = rst_n;
        imem_addr  = drop_addr;
        if (redirect_en) pc_nx = redirect_target;
        if (imem_valid) state_nx = S_FETCH;
        if (!stall) ifid_valid_nx = 1'b0;
      end
      S_HALTED: begin
        if (!stall) ifid_valid_nx = 1'b0;
        if (redirect_en) begin
          pc_nx     = redirect_target;
          halted_nx = 1'b0;
          state_nx  = S_FETCH;
        end
      end
      default: state_nx = S_FETCH;
    endcase
  end

endmodule
